// File: rtl/progloader_axi_burst.sv
// Framed byte-stream program loader: one AXI4-Lite write per assembled word.
// Define PROGLOADER_CHECKSUM_EN to expect and check a trailing XOR checksum byte.
module progloader_axi_burst #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_BYTES  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    reprogram,
    input  logic                    w_processing,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_byte,
    output logic                    busy,
    output logic                    done,
    output logic [2:0]              err,
    output logic [ADDR_WIDTH-1:0]   axi_awaddr,
    output logic                    axi_awvalid,
    input  logic                    axi_awready,
    output logic [DATA_WIDTH-1:0]   axi_wdata,
    output logic [DATA_WIDTH/8-1:0] axi_wstrb,
    output logic                    axi_wvalid,
    input  logic                    axi_wready,
    output logic                    b_ready,
    input  logic                    b_valid,
    input  logic [1:0]              b_response
);

    localparam int unsigned AddrBytes = ADDR_WIDTH / 8;
    localparam int unsigned DataBytes = DATA_WIDTH / 8;
    localparam int unsigned LenW      = 8 * LEN_BYTES;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StAddr  = 3'd1;
    localparam logic [2:0] StLen   = 3'd2;
    localparam logic [2:0] StData  = 3'd3;
    localparam logic [2:0] StDrain = 3'd5;

    localparam logic [1:0] WIdle = 2'd0;
    localparam logic [1:0] WReq  = 2'd1;
    localparam logic [1:0] WResp = 2'd2;

    logic [2:0]            st_q, st_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LenW-1:0]       len_q, len_d;
    logic [DATA_WIDTH-1:0] asm_q, asm_d;
    logic [2:0]            err_q, err_d;
    logic                  done_q, done_d;

    logic                  pend_q, pend_d;
    logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
    logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;

    logic [1:0]            w_st_q, w_st_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;

    logic                  start, abort;
    logic                  word_done, w_free, load_pend, load_new, overrun;
    logic [ADDR_WIDTH-1:0] addr_asm;
    logic [LenW-1:0]       len_asm;
    logic [DATA_WIDTH-1:0] data_asm;

`ifdef PROGLOADER_CHECKSUM_EN
    localparam logic [2:0] StCsum = 3'd4;
    localparam logic [2:0] StTail = StCsum;

    logic [7:0] csum_q, csum_d;

    // Running XOR over every address, count and data byte of the frame.
    always_comb begin
        csum_d = csum_q;
        if (start) begin
            csum_d = 8'h00;
        end else if (rx_valid && reprogram &&
                     (st_q == StAddr || st_q == StLen || st_q == StData)) begin
            csum_d = csum_q ^ rx_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            csum_q <= 8'h00;
        end else begin
            csum_q <= csum_d;
        end
    end
`else
    localparam logic [2:0] StTail = StDrain;
`endif

    // Current field with the incoming byte merged in at its LSB-first position.
    always_comb begin
        addr_asm = addr_q;
        len_asm  = len_q;
        data_asm = asm_q;
        addr_asm[int'(cnt_q) * 8 +: 8] = rx_byte;
        len_asm[int'(cnt_q) * 8 +: 8]  = rx_byte;
        data_asm[int'(cnt_q) * 8 +: 8] = rx_byte;
    end

    assign start     = (st_q == StIdle) && reprogram && w_processing;
    assign abort     = (st_q != StIdle) && !reprogram;
    assign word_done = (st_q == StData) && reprogram && rx_valid &&
                       (cnt_q == 8'(DataBytes - 1));
    assign w_free    = (w_st_q == WIdle) || ((w_st_q == WResp) && b_valid);
    // The slot always goes first so words reach memory in order.
    assign load_pend = pend_q && w_free && reprogram;
    assign load_new  = word_done && w_free && !pend_q;
    assign overrun   = word_done && pend_q && !w_free;

    always_comb begin
        st_d        = st_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        len_d       = len_q;
        asm_d       = asm_q;
        err_d       = err_q;
        done_d      = 1'b0;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        w_st_d      = w_st_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;

        if (start) begin
            st_d  = StAddr;
            cnt_d = 8'd0;
            err_d = 3'b000;
        end else if (abort) begin
            st_d = StIdle;
        end else if (rx_valid) begin
            case (st_q)
                StAddr: begin
                    addr_d = addr_asm;
                    if (cnt_q == 8'(AddrBytes - 1)) begin
                        cnt_d = 8'd0;
                        st_d  = StLen;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                StLen: begin
                    len_d = len_asm;
                    if (cnt_q == 8'(LEN_BYTES - 1)) begin
                        cnt_d = 8'd0;
                        st_d  = (len_asm == '0) ? StTail : StData;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                StData: begin
                    asm_d = data_asm;
                    if (cnt_q == 8'(DataBytes - 1)) begin
                        cnt_d  = 8'd0;
                        addr_d = addr_q + ADDR_WIDTH'(DataBytes);
                        len_d  = len_q - LenW'(1);
                        if (len_q == LenW'(1)) begin
                            st_d = StTail;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
`ifdef PROGLOADER_CHECKSUM_EN
                StCsum: begin
                    if (rx_byte != csum_q) begin
                        err_d[0] = 1'b1;
                    end
                    st_d = StDrain;
                end
`endif
                default: ;
            endcase
        end

        if ((st_q == StDrain) && reprogram && !pend_q && (w_st_q == WIdle)) begin
            done_d = 1'b1;
            st_d   = StIdle;
        end

        if (overrun) begin
            err_d[1] = 1'b1;
        end

        // Pending slot: flushed on abort, refilled in the cycle it drains.
        if (!reprogram) begin
            pend_d = 1'b0;
        end else begin
            if (load_pend) begin
                pend_d = 1'b0;
            end
            if (word_done && !load_new && (!pend_q || load_pend)) begin
                pend_d      = 1'b1;
                pend_addr_d = addr_q;
                pend_data_d = data_asm;
            end
        end

        case (w_st_q)
            WReq: begin
                if (axi_awready) begin
                    awvalid_d = 1'b0;
                end
                if (axi_wready) begin
                    wvalid_d = 1'b0;
                end
                if ((!awvalid_q || axi_awready) && (!wvalid_q || axi_wready)) begin
                    w_st_d   = WResp;
                    bready_d = 1'b1;
                end
            end
            WResp: begin
                if (b_valid) begin
                    if (b_response != 2'b00) begin
                        err_d[2] = 1'b1;
                    end
                    bready_d = 1'b0;
                    w_st_d   = WIdle;
                end
            end
            default: ;
        endcase

        if (load_pend || load_new) begin
            w_st_d    = WReq;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = load_pend ? pend_addr_q : addr_q;
            wdata_d   = load_pend ? pend_data_q : data_asm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q        <= StIdle;
            cnt_q       <= 8'd0;
            addr_q      <= '0;
            len_q       <= '0;
            asm_q       <= '0;
            err_q       <= 3'b000;
            done_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            w_st_q      <= WIdle;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
        end else begin
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            asm_q       <= asm_d;
            err_q       <= err_d;
            done_q      <= done_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            w_st_q      <= w_st_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
        end
    end

    assign busy        = (st_q != StIdle);
    assign done        = done_q;
    assign err         = err_q;
    assign axi_awaddr  = awaddr_q;
    assign axi_awvalid = awvalid_q;
    assign axi_wdata   = wdata_q;
    assign axi_wstrb   = '1;
    assign axi_wvalid  = wvalid_q;
    assign b_ready     = bready_q;

endmodule

// File: tb/tb_progloader_axi_burst.sv
// Directed bench for progloader_axi_burst with a delay-configurable AXI4-Lite slave model.
// Checksum bytes are sent and checked only when PROGLOADER_CHECKSUM_EN is defined.
module tb_progloader_axi_burst;

    logic        clk = 1'b0;
    logic        rst;
    logic        reprogram;
    logic        w_processing;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        busy;
    logic        done;
    logic [2:0]  err;
    logic [31:0] axi_awaddr;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready;
    logic        b_ready;
    logic        b_valid;
    logic [1:0]  b_response;

    always #5 clk = ~clk;

    progloader_axi_burst #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .LEN_BYTES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .reprogram   (reprogram),
        .w_processing(w_processing),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .axi_awaddr  (axi_awaddr),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_wdata   (axi_wdata),
        .axi_wstrb   (axi_wstrb),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .b_ready     (b_ready),
        .b_valid     (b_valid),
        .b_response  (b_response)
    );

    int checks = 0;
    int failures = 0;

    // Slave configuration (written by the stimulus block only).
    int aw_delay = 0;
    int w_delay = 0;
    int b_delay = 0;
    int err_idx = -1;

    // Slave/monitor state (written by the slave block only).
    int aw_wait = 0, w_wait = 0, b_wait = 0;
    int aw_n = 0, w_n = 0, b_n = 0, done_cnt = 0;
    int awv_cyc = 0, wv_cyc = 0, order_err = 0, proto_err = 0;
    logic [31:0] aw_log [32];
    logic [31:0] w_log [32];
    logic        aw_pv = 1'b0, w_pv = 1'b0;
    logic [31:0] aw_pa = '0, w_pd = '0;

    // Snapshots taken at each frame start.
    int aw_base, w_base, done_base, awv_base, wv_base, order_base;
    logic [2:0] err_at_start;
    logic [7:0] last_csum;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // AXI slave and monitor; all decisions at the falling edge.
    initial begin
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        b_valid     = 1'b0;
        b_response  = 2'b00;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (done) done_cnt++;
                if (axi_awvalid) awv_cyc++;
                if (axi_wvalid) wv_cyc++;
                if (b_ready && (axi_awvalid || axi_wvalid)) order_err++;
                if (aw_pv && !axi_awready && (!axi_awvalid || axi_awaddr !== aw_pa)) proto_err++;
                if (w_pv && !axi_wready && (!axi_wvalid || axi_wdata !== w_pd)) proto_err++;
                aw_pv = axi_awvalid;
                aw_pa = axi_awaddr;
                w_pv  = axi_wvalid;
                w_pd  = axi_wdata;

                if (axi_awready) begin
                    axi_awready = 1'b0;
                end else if (axi_awvalid) begin
                    if (aw_wait >= aw_delay) begin
                        axi_awready = 1'b1;
                        aw_log[aw_n % 32] = axi_awaddr;
                        aw_n++;
                        aw_wait = 0;
                    end else aw_wait++;
                end else aw_wait = 0;

                if (axi_wready) begin
                    axi_wready = 1'b0;
                end else if (axi_wvalid) begin
                    if (w_wait >= w_delay) begin
                        axi_wready = 1'b1;
                        w_log[w_n % 32] = axi_wdata;
                        w_n++;
                        w_wait = 0;
                    end else w_wait++;
                end else w_wait = 0;

                if (b_valid) begin
                    b_valid    = 1'b0;
                    b_response = 2'b00;
                end else if (b_ready) begin
                    if (b_wait >= b_delay) begin
                        b_valid    = 1'b1;
                        b_response = (b_n == err_idx) ? 2'b10 : 2'b00;
                        b_n++;
                        b_wait = 0;
                    end else b_wait++;
                end else b_wait = 0;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic start_frame();
        aw_base    = aw_n;
        w_base     = w_n;
        done_base  = done_cnt;
        awv_base   = awv_cyc;
        wv_base    = wv_cyc;
        order_base = order_err;
        reprogram    = 1'b1;
        w_processing = 1'b1;
        @(negedge clk);
        w_processing = 1'b0;
        err_at_start = err;
    endtask

    task automatic run_frame(input logic [31:0] addr, input int cnt,
                             input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                             input int gap, input bit bad_csum);
        logic [7:0]  q[$];
        logic [31:0] words [3];
        logic [15:0] len;
        logic [7:0]  cs;
        words[0] = w0;
        words[1] = w1;
        words[2] = w2;
        len = 16'(cnt);
        for (int i = 0; i < 4; i++) q.push_back(addr[8*i +: 8]);
        for (int i = 0; i < 2; i++) q.push_back(len[8*i +: 8]);
        for (int k = 0; k < cnt; k++)
            for (int i = 0; i < 4; i++) q.push_back(words[k][8*i +: 8]);
        cs = 8'h00;
        foreach (q[i]) cs ^= q[i];
        if (bad_csum) cs = ~cs;
        last_csum = cs;
`ifdef PROGLOADER_CHECKSUM_EN
        q.push_back(cs);
`endif
        start_frame();
        foreach (q[i]) begin
            send_byte(q[i]);
            idle(gap);
        end
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int n = 0;
        while (done_cnt == done_base && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 64'(done_cnt != done_base), 64'd1);
        idle(5);
        check({tag, "_done_once"}, 64'(done_cnt - done_base), 64'd1);
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        reprogram = 1'b0;
        w_processing = 1'b0;
        rx_valid = 1'b0;
        rx_byte = 8'h00;
        idle(3);
        rst = 1'b0;
        @(negedge clk);

        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_awvalid", 64'(axi_awvalid), 64'd0);
        check("rst_wvalid", 64'(axi_wvalid), 64'd0);
        check("rst_bready", 64'(b_ready), 64'd0);
        check("rst_awaddr", 64'(axi_awaddr), 64'd0);
        check("rst_wdata", 64'(axi_wdata), 64'd0);
        check("rst_wstrb", 64'(axi_wstrb), 64'hF);

        // Basic frame with 2-cycle gaps between bytes.
        run_frame(32'h0000_1000, 2, 32'hDEAD_BEEF, 32'h0123_4567, 32'h0, 2, 1'b0);
        wait_done("basic", 500);
        check("basic_nwr", 64'(aw_n - aw_base), 64'd2);
        check("basic_addr0", 64'(aw_log[aw_base % 32]), 64'h1000);
        check("basic_addr1", 64'(aw_log[(aw_base + 1) % 32]), 64'h1004);
        check("basic_data0", 64'(w_log[w_base % 32]), 64'hDEAD_BEEF);
        check("basic_data1", 64'(w_log[(w_base + 1) % 32]), 64'h0123_4567);
        check("basic_err", 64'(err), 64'd0);

        // Address ready held off three cycles.
        aw_delay = 3;
        run_frame(32'h0000_2000, 1, 32'hCAFE_F00D, 32'h0, 32'h0, 0, 1'b0);
        wait_done("stagger", 500);
        check("stagger_nwr", 64'(aw_n - aw_base), 64'd1);
        check("stagger_awv_cycles", 64'(awv_cyc - awv_base), 64'd4);
        check("stagger_wv_cycles", 64'(wv_cyc - wv_base), 64'd1);
        check("stagger_bready_order", 64'(order_err - order_base), 64'd0);
        check("stagger_addr", 64'(aw_log[aw_base % 32]), 64'h2000);
        check("stagger_data", 64'(w_log[w_base % 32]), 64'hCAFE_F00D);
        aw_delay = 0;

        // Slow response with back-to-back bytes: third word overruns the slot.
        b_delay = 200;
        run_frame(32'h0000_3000, 3, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 0, 1'b0);
        wait_done("overrun", 2000);
        check("overrun_err", 64'(err), 64'b010);
        check("overrun_nwr", 64'(aw_n - aw_base), 64'd2);
        check("overrun_addr1", 64'(aw_log[(aw_base + 1) % 32]), 64'h3004);
        check("overrun_data0", 64'(w_log[w_base % 32]), 64'h1111_1111);
        check("overrun_data1", 64'(w_log[(w_base + 1) % 32]), 64'h2222_2222);
        b_delay = 0;

        // SLVERR on the second write of the frame.
        err_idx = b_n + 1;
        run_frame(32'h0000_4000, 3, 32'hA0A0_A0A0, 32'hB1B1_B1B1, 32'hC2C2_C2C2, 0, 1'b0);
        wait_done("bresp", 500);
        check("bresp_err", 64'(err), 64'b100);
        check("bresp_nwr", 64'(aw_n - aw_base), 64'd3);
        check("bresp_addr2", 64'(aw_log[(aw_base + 2) % 32]), 64'h4008);
        check("bresp_data2", 64'(w_log[(w_base + 2) % 32]), 64'hC2C2_C2C2);
        err_idx = -1;

        // Count-zero frame, corrupted checksum when one is sent.
        run_frame(32'h0000_5000, 0, 32'h0, 32'h0, 32'h0, 1, 1'b1);
        check("zero_err_cleared", 64'(err_at_start), 64'd0);
        wait_done("zero", 200);
        check("zero_nwr", 64'(aw_n - aw_base), 64'd0);
`ifdef PROGLOADER_CHECKSUM_EN
        check("zero_err", 64'(err), 64'b001);
`else
        check("zero_err", 64'(err), 64'b000);
`endif

        // Abort after two bytes of the first data word.
        start_frame();
        send_byte(8'h00); send_byte(8'h60); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB);
        check("abort_busy_before", 64'(busy), 64'd1);
        reprogram = 1'b0;
        @(negedge clk);
        check("abort_busy_after", 64'(busy), 64'd0);
        idle(20);
        check("abort_nwr", 64'(aw_n - aw_base), 64'd0);
        check("abort_no_done", 64'(done_cnt - done_base), 64'd0);

        // Address wraps past the top of the space.
        run_frame(32'hFFFF_FFFC, 2, 32'h0BAD_C0DE, 32'h600D_F00D, 32'h0, 0, 1'b0);
        wait_done("wrap", 500);
        check("wrap_addr0", 64'(aw_log[aw_base % 32]), 64'hFFFF_FFFC);
        check("wrap_addr1", 64'(aw_log[(aw_base + 1) % 32]), 64'h0000_0000);
        check("wrap_data1", 64'(w_log[(w_base + 1) % 32]), 64'h600D_F00D);
        check("wrap_err", 64'(err), 64'd0);

        check("proto_stable", 64'(proto_err), 64'd0);
        check("bready_order", 64'(order_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/progloader_axi_burst.md
Name: progloader_axi_burst

Overview:
- Generalised program loader. Consumes a framed byte stream: addressed, length-prefixed blocks of words, least-significant byte first.
- Issues one AXI4-Lite write per assembled word. Address auto-increments by DATA_WIDTH/8.
- Sits between a standalone UART receiver and the instruction/data memory interconnect.
- Differences from the single-word loader: parametrised width, multi-word frames, overlap of byte reception with the outstanding write, sticky error reporting.

Parameters:
- ADDR_WIDTH, 32: AXI address width; multiple of 8, range 16..64.
- DATA_WIDTH, 32: AXI data width; multiple of 8, range 8..64.
- LEN_BYTES, 2: bytes in the word-count field; count range 0..2^(8*LEN_BYTES)-1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- reprogram  in  1  loader enable; deasserting it aborts the frame.
- w_processing  in  1  start gate; a frame may start only while high.
- rx_valid  in  1  one-cycle strobe; rx_byte is valid.
- rx_byte  in  8  received byte.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a frame completes.
- err  out  3  sticky flags: [0] checksum mismatch, [1] overrun, [2] bresp != OKAY.
- axi_awaddr  out  ADDR_WIDTH  write address.
- axi_awvalid  out  1  address valid.
- axi_awready  in  1  address ready.
- axi_wdata  out  DATA_WIDTH  write data.
- axi_wstrb  out  DATA_WIDTH/8  write strobe; constant all ones.
- axi_wvalid  out  1  data valid.
- axi_wready  in  1  data ready.
- b_ready  out  1  response ready.
- b_valid  in  1  response valid.
- b_response  in  2  response code.

Behaviour:
- Reset values: all outputs 0 except axi_wstrb; err cleared; frame FSM and write FSM both at IDLE.
- Frame format: ADDR_WIDTH/8 address bytes, LEN_BYTES count bytes, count×(DATA_WIDTH/8) data bytes, optional checksum byte. All fields LSB first.
- Frame FSM states: IDLE, ADDR, LEN, DATA, CSUM, DRAIN.
- IDLE:
  - Move to ADDR when reprogram && w_processing.
  - The byte that arrives in that same cycle is not consumed.
  - err is cleared on this transition.
- ADDR: collect bytes into a base-address register; go to LEN after the last address byte.
- LEN:
  - Collect the count bytes.
  - Count 0 goes directly to CSUM (or DRAIN if the checksum is compiled out); no writes are issued.
  - Otherwise go to DATA.
- DATA:
  - Assemble bytes into an assembly register.
  - On the last byte of a word, hand the word to the write FSM if it is in W_IDLE.
  - If the write FSM is busy, hold the word in a one-entry pending slot.
  - If a further word completes while the slot is still full, set err[1] and drop the new word; the address still advances.
  - After the final word go to CSUM (or DRAIN).
- CSUM: compare the byte with the XOR of all frame bytes before it; set err[0] on mismatch; go to DRAIN.
- DRAIN:
  - Wait until the pending slot is empty and the write FSM is in W_IDLE.
  - Then pulse done for one cycle and return to IDLE.
- Write FSM states: W_IDLE, W_REQ, W_RESP.
  - Loading a word drives axi_awaddr, axi_wdata, axi_awvalid=1 and axi_wvalid=1 in the next cycle (W_REQ).
  - Each valid drops independently on its own ready; both handshakes may complete in the same cycle.
  - Once both handshakes are done, go to W_RESP with b_ready=1.
  - On b_valid: set err[2] if b_response != 2'b00, drop b_ready, go to W_IDLE.
  - In that same cycle, the pending slot, if full, is loaded directly into W_REQ.
  - Valid must not drop before its ready, and data/address must not change while valid.
- Addressing: word k goes to base + k×(DATA_WIDTH/8), computed modulo 2^ADDR_WIDTH (wraps silently).
- Byte acceptance: a byte is consumed only in the cycle rx_valid=1; gaps of any length between bytes are legal.
- reprogram low mid-frame:
  - Frame FSM returns to IDLE immediately; the partial word is discarded; no done pulse.
  - An outstanding AXI transaction always completes, including the response; the pending slot is flushed.
- rst mid-transaction: immediate return to reset values. The interconnect must be reset together with this block.

Optional Feature:
- Macro: PROGLOADER_CHECKSUM_EN.
- Defined: the trailing checksum byte is expected and checked; a mismatch sets err[0].
- Undefined: no CSUM state and no checksum byte; the frame ends after the last data word; err[0] stays 0.

Test Plan:
- Basic frame (DATA_WIDTH=32): addr 0x00001000, count 2, words 0xDEADBEEF, 0x01234567, correct checksum, ready signals always high -> writes to 0x1000 and 0x1004 with matching data; done pulses once; err=000.
- Staggered handshake: awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle; awvalid held 4 cycles; exactly one write; b_ready rises only after both handshakes.
- Overrun: count 3, b_valid delayed 200 cycles, bytes back-to-back -> word 2 held in the pending slot, word 3 dropped; err[1]=1; only words 1–2 written.
- Error response: b_response=2'b10 on the second write -> err[2]=1, third write still issued, done pulses; err cleared at the next frame start.
- Checksum mismatch and count 0: count-0 frame with a corrupted checksum -> no AXI activity, err[0]=1, done pulses.
- Abort: reprogram deasserted after 2 data bytes of word 1 -> busy=0 on the next cycle, no write issued, no done pulse.
